// File: rtl/neuron_mac_q12.sv
// neuron_mac_q12: streaming Q4.12 multiply-accumulate feeding a pipelined activation
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid / in_ready / in_a / in_w / in_last / bias : beat stream, bias taken with the last beat
//   out_valid / out_ready / out_x : saturated Q4.12 result, held until accepted
//   act_valid  pulse marking the activation's registered y for the handed-off x
module neuron_mac_q12 #(
    parameter int WIDTH       = 16,
    parameter int FP          = 12,
    parameter int ACC_WIDTH   = 40,
    parameter int ACT_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_w,
    input  logic                    in_last,
    input  logic signed [WIDTH-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic                    act_valid
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] X_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] X_MIN = ~X_MAX;

    typedef enum logic [1:0] {ACC, DRAIN, FIN, OUT} state_t;

    state_t                  state;
    logic signed [PW-1:0]    prod;
    logic                    prod_vld;
    logic signed [ACC_WIDTH-1:0] acc, sum, scaled;
    logic signed [WIDTH-1:0] bias_r, sat_x;
    logic [ACT_LATENCY-1:0]  dl;
    logic                    take, fire;

    // in_ready is forced low while reset is held so nothing looks accepted during reset
    assign in_ready  = rst && state == ACC;
    assign take      = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign act_valid = dl[ACT_LATENCY-1];

    // bias is aligned to the product scale (2*FP fractional bits) before rescaling
    always_comb begin
        sum    = acc + {{(ACC_WIDTH-WIDTH-FP){bias_r[WIDTH-1]}}, bias_r, {FP{1'b0}}};
        scaled = sum >>> FP;
        sat_x  = scaled > X_MAX ? X_MAX[WIDTH-1:0] :
                 scaled < X_MIN ? X_MIN[WIDTH-1:0] : scaled[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACC;
            prod      <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
            bias_r    <= '0;
            out_x     <= '0;
            out_valid <= 1'b0;
        end else begin
            prod_vld <= take;
            if (take) prod <= PW'(in_a) * PW'(in_w);
            if (prod_vld) acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            case (state)
                ACC: if (take && in_last) begin
                    bias_r <= bias;
                    state  <= DRAIN;
                end
                DRAIN: state <= FIN;
                FIN: begin
                    out_x     <= sat_x;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    state     <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

    // delay line runs free of the FSM so pulses stay in flight across new vectors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dl <= '0;
        else      dl <= {dl[ACT_LATENCY-2:0], fire};
    end
endmodule

// File: tb/tb_neuron_mac_q12.sv
// tb_neuron_mac_q12: randomized and directed scoreboard bench for neuron_mac_q12
module tb_neuron_mac_q12;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [15:0] in_a = '0, in_w = '0, bias = '0;
    logic in_last = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [15:0] out_x;
    logic act_valid;

    int errors = 0, checks = 0;
    int cyc = 0, last_cyc = -100;
    int ready_mode = 0;
    bit prev_ov = 1'b0;
    logic signed [15:0] exp_q[$];
    int act_q[$];
    logic signed [15:0] va[$], vw[$];

    neuron_mac_q12 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_w(in_w), .in_last(in_last), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .act_valid(act_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // reference: exact dot product + bias, floor-divided to Q4.12 and clamped
    function automatic logic signed [15:0] model(input int b);
        longint s = longint'(b) * 4096;
        longint q;
        foreach (va[i]) s += longint'(va[i]) * longint'(vw[i]);
        q = s / 4096;
        if (s % 4096 != 0 && s < 0) q--;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (act_valid) begin
                if (act_q.size() != 0 && act_q[0] == cyc) begin
                    check("act_valid_timing", cyc, act_q.pop_front());
                end else check("act_valid_unexpected", cyc, act_q.size() != 0 ? act_q[0] : -1);
            end
            while (act_q.size() != 0 && act_q[0] < cyc) check("act_valid_missed", -1, act_q.pop_front());
            if (out_valid && !prev_ov) check("out_latency", cyc, last_cyc + 2);
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) check("out_x", out_x, exp_q.pop_front());
                else check("out_unexpected", out_x, -99999);
                act_q.push_back(cyc + 4);
            end
        end
        prev_ov = out_valid;
    end

    task automatic send_beat(input logic signed [15:0] a, input logic signed [15:0] w,
                             input logic last, input logic signed [15:0] b);
        int t = 0;
        in_valid = 1'b1; in_a = a; in_w = w; in_last = last; bias = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        if (last) last_cyc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_vec(input int b, input int gap);
        foreach (va[i]) begin
            send_beat(va[i], vw[i], i == va.size() - 1, 16'(b));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        exp_q.push_back(model(b));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || act_q.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) check("drain_timeout", exp_q.size() + act_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [15:0] held;
        int t;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_x", out_x, 0);
        check("reset_act_valid", act_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        va = {16'sd4096}; vw = {16'sd2048};
        run_vec(0, 0);
        check("model_single", exp_q[$], 2048);
        va = {16'sd4096, 16'sd8192, 16'sd2048}; vw = {16'sd4096, -16'sd2048, 16'sd2048};
        run_vec(1024, 2);
        va = {16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767}; vw = va;
        run_vec(0, 0);
        va = {-16'sd32768, -16'sd32768}; vw = {16'sd32767, 16'sd32767};
        run_vec(0, 0);
        va = {16'sd1}; vw = {16'sd1};
        run_vec(0, 0);
        va = {-16'sd1}; vw = {16'sd1};
        run_vec(0, 0);
        wait_drain();

        ready_mode = 1;
        va = {16'sd4096, 16'sd4096}; vw = {16'sd4096, 16'sd1024};
        run_vec(0, 0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", out_valid, 1);
        held = out_x;
        in_valid = 1'b1; in_a = 16'sd8192; in_w = 16'sd4096; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_x_stable", out_x, held);
        end
        ready_mode = 0;
        va = {16'sd8192}; vw = {16'sd4096};
        run_vec(0, 0);
        wait_drain();

        va = {16'sd4096, 16'sd4096}; vw = {16'sd4096, 16'sd4096};
        send_beat(va[0], vw[0], 1'b0, 16'sd0);
        send_beat(va[1], vw[1], 1'b0, 16'sd0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_act_valid", act_valid, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        va = {16'sd4096}; vw = {16'sd4096};
        run_vec(0, 0);
        check("model_after_reset", exp_q[$], 4096);
        wait_drain();

        ready_mode = 2;
        for (int v = 0; v < 25; v++) begin
            int n = $urandom_range(1, 8);
            va.delete(); vw.delete();
            for (int i = 0; i < n; i++) begin
                va.push_back(16'($urandom));
                vw.push_back(v < 12 ? 16'($urandom_range(0, 8191)) - 16'sd4096 : 16'($urandom));
            end
            run_vec(int'($signed(16'($urandom))), $urandom_range(0, 2));
        end
        wait_drain();
        ready_mode = 0;
        repeat (8) @(posedge clk);
        #1;
        check("pending_results", exp_q.size(), 0);
        check("pending_act", act_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/neuron_mac_q12.md
Name: neuron_mac_q12

Overview:
- Per-neuron multiply-accumulate stage sitting directly upstream of the piecewise-linear sigmoid activation.
- Consumes a stream of Q4.12 (activation, weight) beats and accumulates the dot product at full precision.
- On the last beat, adds a Q4.12 bias, rescales to Q4.12, saturates to 16 bits and presents the result as the activation input x.
- Emits a delay-matched valid flag that marks the cycle in which the activation output y for that x is ready.

Parameters:
- WIDTH, 16, operand/result width (signed, Q(WIDTH-FP).FP).
- FP, 12, fractional bits of operands, bias and result.
- ACC_WIDTH, 40, signed accumulator width; products are 2*WIDTH bits, sign-extended into it.
- ACT_LATENCY, 4, register stages of the downstream activation counted from the edge that samples x; sets the act_valid delay.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready.
- in_a  in  WIDTH  signed activation, Q4.12.
- in_w  in  WIDTH  signed weight, Q4.12.
- in_last  in  1  marks the final beat of a dot product.
- bias  in  WIDTH  signed bias, Q4.12; sampled on the edge that accepts the in_last beat.
- out_valid  out  1  out_x holds a finished result.
- out_ready  in  1  downstream accepts out_x.
- out_x  out  WIDTH  saturated signed Q4.12 pre-activation; drives the activation's x input.
- act_valid  out  1  one-cycle pulse aligned with the activation's registered y for the result just handed off.

Behaviour:
- Reset (rst low, async): state ACC; accumulator, product register, out_x, delay line cleared; out_valid=0, act_valid=0, in_ready=1 once released. Reset mid-dot-product discards the partial sum; no output is produced for it.
- FSM states:
  - ACC: in_ready=1. Each accepted beat registers prod = in_a*in_w (signed, 2*WIDTH). prod_vld adds into acc one edge later. An accepted in_last beat also captures bias and moves to DRAIN.
  - DRAIN (1 cycle): in_ready=0. The last product is added; go to FIN.
  - FIN (1 cycle): out_x <= sat(floor((acc + (sext(bias) << FP)) / 2^FP)). Arithmetic right shift, so truncation is toward minus infinity. Clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Set out_valid; go to OUT.
  - OUT: in_ready=0; out_x and out_valid held stable. On an edge with out_ready=1 (fire): out_valid<=0, acc<=0, state ACC.
- Latency: last beat accepted at edge E0 -> out_valid high after edge E0+2. Minimum period between results is N+3 cycles for N beats, with out_ready held high.
- Gaps: in_valid low in ACC is allowed; acc holds, no beat counted.
- Single-beat dot product (in_last on first beat) is legal.
- The accumulator wraps modulo 2^ACC_WIDTH, with no internal saturation. Up to 256 full-scale beats are guaranteed exact; saturation is applied only at FIN.
- act_valid: shift register of fire, ACT_LATENCY deep. act_valid is high exactly ACT_LATENCY-1 edges after the fire edge, one cycle wide per fire. out_x is held through the fire edge so the activation samples it on that edge.
- The delay line is independent of the FSM, so a new dot product can proceed while act_valid pulses are in flight.

Test Plan:
- Single beat a=4096, w=2048, last=1, bias=0 -> out_valid 2 edges later, out_x=2048; fire -> act_valid pulses 3 edges after the fire edge.
- Three beats (4096,4096), (8192,-2048), (2048,2048), bias=1024, in_valid gapped by 2 idle cycles mid-stream -> out_x=2048.
- Saturation: four beats a=32767, w=32767, bias=0 -> out_x=32767; two beats a=-32768, w=32767 -> out_x=-32768.
- Truncation: a=1, w=1, bias=0 -> out_x=0; a=-1, w=1, bias=0 -> out_x=-1 (floor).
- Backpressure: out_ready low 5 cycles in OUT -> in_ready=0, offered beats not accepted, out_x stable. Raise out_ready -> single act_valid pulse; next vector then accumulates from 0.
- Reset asserted after 2 of 4 beats -> all outputs 0 immediately; after release, a fresh 1-beat vector (4096,4096), bias=0 gives out_x=4096.
